// File: rtl/cosim_commit_buffer_pkg.sv
// Shared types for the co-simulation commit path: the retire record and the commit port count.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package cosim_pkg;

    localparam int NR_COMMIT_PORTS = 2;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] insn;
        logic [4:0]  rd;
        logic [63:0] rd_data;
        logic        rd_we;
        logic        is_fp;
        logic        exception;
        logic [7:0]  hartid;
    } commit_rec_t;

endpackage

// File: rtl/cosim_commit_buffer_if.sv
// Bundle between the core commit ports / Spike checker and the commit buffer.
// Latency: n/a (wiring only).
// Backpressure: rec_ready_i from the checker; stall_o back to the core.
//
// Signals: commit_valid_i/commit_rec_i (core -> buffer), rec_valid_o/rec_o/rec_ready_i
// (buffer <-> checker), seq_o/count_o/stall_o/overflow_o/hang_o (status).
// modport slave is the buffer; modport master is the core+checker side.
interface cosim_commit_buffer_if
    import cosim_pkg::*;
#(
    parameter int DEPTH = 16
) ();

    localparam int CW = $clog2(DEPTH) + 1;

    logic [NR_COMMIT_PORTS-1:0]  commit_valid_i;
    commit_rec_t [NR_COMMIT_PORTS-1:0] commit_rec_i;
    logic                        rec_valid_o;
    logic                        rec_ready_i;
    commit_rec_t                 rec_o;
    logic [63:0]                 seq_o;
    logic [CW-1:0]               count_o;
    logic                        stall_o;
    logic                        overflow_o;
    logic                        hang_o;

    modport master (
        output commit_valid_i, commit_rec_i, rec_ready_i,
        input  rec_valid_o, rec_o, seq_o, count_o, stall_o, overflow_o, hang_o
    );

    modport slave (
        input  commit_valid_i, commit_rec_i, rec_ready_i,
        output rec_valid_o, rec_o, seq_o, count_o, stall_o, overflow_o, hang_o
    );

endinterface

// File: rtl/cosim_commit_buffer_hang_wdog.sv
// Hang watchdog: sticky flag once no commit has been seen for HANG_CYCLES cycles.
// Latency: hang_o is registered; it rises on the edge where the idle count reaches HANG_CYCLES.
// Backpressure: none.
//
// Ports: clk_i, rst_i (async active-high), activity_i (any commit strobe), hang_o (sticky).
// HANG_CYCLES = 0 disables the flag entirely.
module cosim_hang_wdog #(
    parameter int HANG_CYCLES = 100000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic activity_i,
    output logic hang_o
);

    localparam int          W     = (HANG_CYCLES > 1) ? $clog2(HANG_CYCLES + 1) : 1;
    localparam logic [W-1:0] LIMIT = W'(HANG_CYCLES);

    logic [W-1:0] idle_q;
    logic [W-1:0] idle_next;
    logic         hang_q;

    // Saturate at the limit so a long stall never wraps back below it.
    always_comb begin
        idle_next = idle_q;
        if (activity_i) begin
            idle_next = '0;
        end else if (idle_q != LIMIT) begin
            idle_next = idle_q + W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            idle_q <= '0;
            hang_q <= 1'b0;
        end else begin
            idle_q <= idle_next;
            if ((HANG_CYCLES != 0) && (idle_next == LIMIT)) begin
                hang_q <= 1'b1;
            end
        end
    end

    assign hang_o = hang_q;

endmodule

// File: rtl/cosim_commit_buffer.sv
// Program-order buffer of retired instructions (up to 2 pushed/cycle) feeding the Spike checker.
// Latency: 1 cycle push-to-visible; rec_o is read combinationally from the head slot.
// Backpressure: checker via rec_ready_i; core via registered stall_o when COSIM_COMMIT_STALL_EN is defined.
//
// Ports: clk_i, rst_i (async active-high), bus (cosim_commit_buffer_if.slave) carrying
// commit_valid_i/commit_rec_i, rec_valid_o/rec_ready_i/rec_o, seq_o, count_o, stall_o,
// overflow_o, hang_o.
// Optional feature macro: COSIM_COMMIT_STALL_EN (registered stall; overflow also raises $error).
// Without it stall_o is tied low and overflow only sets the sticky overflow_o.
module cosim_commit_buffer
    import cosim_pkg::*;
#(
    parameter int DEPTH       = 16,
    parameter int HANG_CYCLES = 100000,
    parameter int HART_ID     = 0
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    cosim_commit_buffer_if.slave   bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    commit_rec_t mem [DEPTH];

    logic [AW-1:0] wp_q;
    logic [AW-1:0] rp_q;
    logic [CW-1:0] cnt_q;
    logic [63:0]   seq_q;
    logic          ovf_q;

    logic [CW-1:0] free_slots;
    logic [CW-1:0] n_valid;
    logic [CW-1:0] n_push;
    logic [CW-1:0] cnt_next;
    logic          drop;
    logic          pop;
    logic [AW-1:0] wp_p1;
    commit_rec_t   first_rec;
    commit_rec_t   head_rec;

    // Free space is taken before this cycle's pop: a slot freed by a pop only
    // becomes writable on the following cycle.
    always_comb begin
        free_slots = CW'(DEPTH) - cnt_q;
        n_valid    = CW'(bus.commit_valid_i[0]) + CW'(bus.commit_valid_i[1]);
        drop       = (n_valid > free_slots);
        n_push     = drop ? free_slots : n_valid;
        // A lone port-1 commit takes the slot port 0 would have used.
        first_rec  = bus.commit_valid_i[0] ? bus.commit_rec_i[0] : bus.commit_rec_i[1];
        pop        = (cnt_q != '0) && bus.rec_ready_i;
        cnt_next   = cnt_q + n_push - CW'(pop);
        wp_p1      = wp_q + AW'(1);
    end

    // Storage carries no reset; the head is masked to zero whenever empty.
    always_ff @(posedge clk_i) begin
        if (n_push != '0) begin
            mem[wp_q] <= first_rec;
        end
        if (n_push == CW'(2)) begin
            mem[wp_p1] <= bus.commit_rec_i[1];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
            seq_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            wp_q  <= wp_q + AW'(n_push);
            rp_q  <= rp_q + AW'(pop);
            cnt_q <= cnt_next;
            seq_q <= seq_q + 64'(pop);
            if (drop) begin
                ovf_q <= 1'b1;
            end
        end
    end

    always_comb begin
        head_rec = '0;
        if (cnt_q != '0) begin
            head_rec        = mem[rp_q];
            head_rec.hartid = 8'(HART_ID);
        end
    end

`ifdef COSIM_COMMIT_STALL_EN
    logic stall_q;

    // Two slots of headroom cover the commit already in flight when the core sees stall.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_q <= 1'b0;
        end else begin
            stall_q <= (cnt_next >= CW'(DEPTH - 2));
        end
    end

    assign bus.stall_o = stall_q;

    // With stall honoured an overflow can only be a core protocol violation.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            assert (!drop) else $error("cosim_commit_buffer: commit dropped while stall_o protocol is active");
        end
    end
`else
    assign bus.stall_o = 1'b0;
`endif

    cosim_hang_wdog #(
        .HANG_CYCLES (HANG_CYCLES)
    ) u_hang_wdog (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .activity_i (|bus.commit_valid_i),
        .hang_o     (bus.hang_o)
    );

    assign bus.rec_valid_o = (cnt_q != '0);
    assign bus.rec_o       = head_rec;
    assign bus.seq_o       = seq_q;
    assign bus.count_o     = cnt_q;
    assign bus.overflow_o  = ovf_q;

endmodule

// File: tb/tb_cosim_commit_buffer.sv
module tb_cosim_commit_buffer;
    import cosim_pkg::*;

    localparam int DEPTH = 16;
    localparam int HANG  = 10;
    localparam int HART  = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    cosim_commit_buffer_if #(.DEPTH(DEPTH)) bus ();

    cosim_commit_buffer #(
        .DEPTH       (DEPTH),
        .HANG_CYCLES (HANG),
        .HART_ID     (HART)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    commit_rec_t sbq[$];
    int          n_total = 0;
    int          n_pass  = 0;
    int          n_fail  = 0;
    logic        m_ovf   = 1'b0;
    logic [63:0] m_seq   = '0;
    commit_rec_t zrec;

    task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic commit_rec_t mk(input logic [63:0] pc);
        commit_rec_t r;
        r.pc        = pc;
        r.insn      = pc[31:0] ^ 32'h0000_0013;
        r.rd        = pc[6:2];
        r.rd_data   = ~pc;
        r.rd_we     = pc[2];
        r.is_fp     = pc[3];
        r.exception = 1'b0;
        r.hartid    = 8'hAA;
        return r;
    endfunction

    function automatic commit_rec_t with_hart(input commit_rec_t r);
        commit_rec_t o;
        o        = r;
        o.hartid = 8'(HART);
        return o;
    endfunction

    // Called at posedge+1; drives one cycle of stimulus, checks the head before the
    // edge and the status outputs after it.
    task automatic step(input logic [1:0] v, input commit_rec_t r0, input commit_rec_t r1,
                        input logic rdy);
        int free;
        int size_pre;
        logic exp_stall;
        bus.commit_valid_i  = v;
        bus.commit_rec_i[0] = r0;
        bus.commit_rec_i[1] = r1;
        bus.rec_ready_i     = rdy;
        #3;
        size_pre = sbq.size();
        free     = DEPTH - size_pre;
        chk("rec_valid", 192'(bus.rec_valid_o), 192'(size_pre != 0));
        if (size_pre != 0) begin
            chk("rec_head", 192'(bus.rec_o), 192'(with_hart(sbq[0])));
            if (rdy) begin
                void'(sbq.pop_front());
                m_seq++;
            end
        end else begin
            chk("rec_empty", 192'(bus.rec_o), 192'(zrec));
        end
        if (v[0]) begin
            if (free > 0) begin sbq.push_back(r0); free--; end
            else m_ovf = 1'b1;
        end
        if (v[1]) begin
            if (free > 0) begin sbq.push_back(r1); free--; end
            else m_ovf = 1'b1;
        end
`ifdef COSIM_COMMIT_STALL_EN
        exp_stall = (sbq.size() >= DEPTH - 2);
`else
        exp_stall = 1'b0;
`endif
        @(posedge clk);
        #1;
        chk("count", 192'(bus.count_o), 192'(sbq.size()));
        chk("overflow", 192'(bus.overflow_o), 192'(m_ovf));
        chk("seq", 192'(bus.seq_o), 192'(m_seq));
        chk("stall", 192'(bus.stall_o), 192'(exp_stall));
    endtask

    // Asserts reset between edges, checks outputs cleared asynchronously, releases at posedge+1.
    task automatic do_reset();
        @(posedge clk);
        bus.commit_valid_i = '0;
        bus.rec_ready_i    = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("rst_rec_valid", 192'(bus.rec_valid_o), 192'(0));
        chk("rst_rec", 192'(bus.rec_o), 192'(zrec));
        chk("rst_seq", 192'(bus.seq_o), 192'(0));
        chk("rst_count", 192'(bus.count_o), 192'(0));
        chk("rst_stall", 192'(bus.stall_o), 192'(0));
        chk("rst_overflow", 192'(bus.overflow_o), 192'(0));
        chk("rst_hang", 192'(bus.hang_o), 192'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        sbq.delete();
        m_ovf = 1'b0;
        m_seq = '0;
    endtask

    initial begin
        zrec               = '0;
        bus.commit_valid_i = '0;
        bus.commit_rec_i   = '0;
        bus.rec_ready_i    = 1'b0;

        do_reset();

        // Single commit, visible next cycle, then popped.
        step(2'b01, mk(64'h8000_0000), zrec, 1'b1);
        step(2'b00, zrec, zrec, 1'b1);

        // Dual-port commits with checker stalled: 8 entries.
        for (int i = 0; i < 4; i++) step(2'b11, mk(64'h100), mk(64'h104), 1'b0);
        for (int i = 0; i < 3; i++) step(2'b11, mk(64'h110), mk(64'h114), 1'b0);
        step(2'b01, mk(64'h120), zrec, 1'b0);
        // 15 entries: only the older of two commits fits.
        step(2'b11, mk(64'h300), mk(64'h304), 1'b0);
        // Full: a push alongside a pop is still dropped.
        step(2'b01, mk(64'h310), zrec, 1'b1);
        for (int i = 0; i < 16; i++) step(2'b00, zrec, zrec, 1'b1);

        // Lone port-1 commit lands in the next slot, after an older entry.
        step(2'b01, mk(64'h210), zrec, 1'b0);
        step(2'b10, zrec, mk(64'h200), 1'b0);
        for (int i = 0; i < 3; i++) step(2'b00, zrec, zrec, 1'b1);

        // Reset with five entries buffered.
        step(2'b11, mk(64'h400), mk(64'h404), 1'b0);
        step(2'b11, mk(64'h408), mk(64'h40c), 1'b0);
        step(2'b01, mk(64'h410), zrec, 1'b0);
        do_reset();
        step(2'b00, zrec, zrec, 1'b1);

        // Watchdog from reset release with no commits.
        do_reset();
        for (int i = 1; i <= 12; i++) begin
            step(2'b00, zrec, zrec, 1'b0);
            chk("hang_idle", 192'(bus.hang_o), 192'(i >= HANG));
        end

        // Commit sampled on edge 5 restarts the idle count.
        do_reset();
        for (int i = 1; i <= 16; i++) begin
            step((i == 5) ? 2'b01 : 2'b00, mk(64'h500), zrec, 1'b0);
            chk("hang_delayed", 192'(bus.hang_o), 192'(i >= 15));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/cosim_commit_buffer.md
# cosim_commit_buffer

Captures instructions retired by one core's commit stage, up to two per cycle, and buffers them in program order for the MEEP co-simulation checker. The checker pops one record per handshake and steps Spike against it. The block sits between the core's commit ports and the Spike DPI stepper. It also provides overflow detection, a retired-instruction sequence count, and a hang watchdog.

## Interface
- `DEPTH`, 16: buffer entries; power of two, ≥4.
- `HANG_CYCLES`, 100000: cycles with no commit before `hang_o` asserts; 0 disables the watchdog.
- `HART_ID`, 0: hart index carried in every output record.
- `clk_i` in 1: clock.
- `rst_i` in 1: asynchronous, active-high reset.
- `commit_valid_i` in 2: per-port retire strobe; port 0 is older.
- `commit_rec_i` in 2×`commit_rec_t`: retire records (pc, insn, rd, rd_data, rd_we, is_fp, exception).
- `rec_valid_o` out 1: head record available.
- `rec_ready_i` in 1: checker consumes the head.
- `rec_o` out `commit_rec_t`: head record, with hartid filled from `HART_ID`.
- `seq_o` out 64: count of records popped.
- `count_o` out $clog2(DEPTH)+1: current occupancy.
- `stall_o` out 1: backpressure to the core (see Configuration).
- `overflow_o` out 1: sticky, set when a commit is dropped.
- `hang_o` out 1: sticky watchdog flag.

## Operation
- Circular buffer with write pointer `wp`, read pointer `rp` and occupancy `cnt`. Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
- Push order per cycle: port 0 first, then port 1. If only port 1 is valid, it takes the slot that port 0 would have taken.
- Free slots are `DEPTH - cnt`, evaluated before this cycle's pop. Pop does not free a slot in the same cycle, so there is no same-cycle bypass.
- If the valid commits exceed the free slots:
  - The oldest commits that fit are written.
  - The remaining commits are dropped.
  - `overflow_o` sets and stays set until reset.
- Pop occurs when `rec_valid_o && rec_ready_i`. Pop advances `rp` and increments `seq_o`, which wraps modulo 2^64.
- `cnt_next = cnt + pushes - pop`. Push and pop in the same cycle are legal at any occupancy.
- `rec_valid_o = (cnt != 0)`. `rec_o` is read combinationally from the storage at `rp`.
- Watchdog:
  - The idle counter resets to 0 on any `commit_valid_i` bit.
  - Otherwise the counter increments, saturating at `HANG_CYCLES`.
  - `hang_o` sets when the counter reaches `HANG_CYCLES`, and stays set until reset.
- Reset mid-operation: all contents are discarded immediately. The checker must re-sync Spike.
- Reset values: `rec_valid_o`=0, `rec_o`=0, `seq_o`=0, `count_o`=0, `stall_o`=0, `overflow_o`=0, `hang_o`=0, and the pointers and idle counter are 0.

## Timing
- Push-to-visible latency is 1 cycle. A record committed in cycle N appears at `rec_o` in N+1 if the buffer was empty.
- Throughput: 2 pushes and 1 pop per cycle.
- `rec_o` must stay stable while `rec_valid_o && !rec_ready_i`.
- `stall_o` is registered, asserting 1 cycle after its condition is met.

## Configuration
- `COSIM_COMMIT_STALL_EN` defined:
  - `stall_o` asserts (registered) when `cnt_next >= DEPTH-2`.
  - The core holds commits while stalled, which guarantees the buffer never overflows.
  - An overflow is then a core protocol bug. The block flags it with `overflow_o` and also reports it with `$error`.
- Not defined:
  - `stall_o` is tied to 0.
  - Overflow drops commits silently apart from `overflow_o`.
  - The checker must treat a set `overflow_o` as loss of lockstep.

## Structure
- Shared package `cosim_pkg` holds:
  - `commit_rec_t` (pc[63:0], insn[31:0], rd[4:0], rd_data[63:0], rd_we, is_fp, exception, hartid[7:0]).
  - `NR_COMMIT_PORTS = 2`.
- One sub-module, `cosim_hang_wdog`, holds the idle counter and `hang_o`. Everything else is flat in the top.

## Test plan
- Reset, then one commit on port 0 with pc=0x8000_0000 and `rec_ready_i`=1 → `rec_valid_o` high in the next cycle with pc 0x8000_0000, then `seq_o`=1.
- Both ports valid (pc 0x100, 0x104) for 4 cycles with `rec_ready_i`=0, DEPTH=16:
  - Pop order is 0x100, 0x104, 0x100, … .
  - `count_o`=8.
  - With the macro defined, `stall_o`=0.
- Fill to 15, then push 2 with no pop, macro undefined → one record written, `count_o`=16, `overflow_o`=1 sticky, port-1 record absent from pop stream.
- Only port 1 valid with pc 0x200 → stored at the next slot; popped next in order.
- Full buffer, single push plus pop in the same cycle → push dropped (pre-pop free slots = 0), `overflow_o`=1, `count_o`=15.
- HANG_CYCLES=10, no commits → `hang_o` rises exactly 10 cycles after reset release. A commit at cycle 5 delays the rise to cycle 15.
- Assert `rst_i` with 5 entries buffered → all outputs are 0 asynchronously. After release, the buffer is empty.
